ledframe_spi_tx: RTL

Transmit side of the LED-matrix serial link. It captures a 128-bit two-matrix frame (upper 64 bits are the X matrix, lower 64 bits the Y matrix), then shifts it out MSB first on `sck`/`sdo`, with `load` framing the transfer. The receiver samples on the rising edge of `sck` while `load` is high. The block sits in the controller FPGA, or in a test harness, and drives the `sck`/`sdi`/`load` pins of the display board.

---
 rtl/ledframe_spi_tx_if.sv | 34 +++
 rtl/ledframe_spi_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ledframe_spi_tx_if.sv
// Pin bundle between a frame source and the LED-matrix serial transmitter.
// Carries the start/frame request, status flags and the sck/sdo/load link pins.
// master = frame source / board side, slave = transmitter.
interface ledframe_spi_tx_if #(
    parameter int N_BITS = 128
);
    logic              start;
    logic [N_BITS-1:0] frame;
    logic              busy;
    logic              done;
    logic              sck;
    logic              sdo;
    logic              load;

    modport master (
        output start,
        output frame,
        input  busy,
        input  done,
        input  sck,
        input  sdo,
        input  load
    );

    modport slave (
        input  start,
        input  frame,
        output busy,
        output done,
        output sck,
        output sdo,
        output load
    );
endinterface

// File: rtl/ledframe_spi_tx.sv
// Serialises an N_BITS frame MSB first on sck/sdo (CPOL=0, CPHA=0), framed by load.
// Latency: first sck rise 1+CLK_DIV cycles after start; done (2*N_BITS+1)*CLK_DIV+1 cycles after start.
// Backpressure: start is only honoured in IDLE; requests while busy are dropped, not queued.
module ledframe_spi_tx #(
    parameter int N_BITS  = 128,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    ledframe_spi_tx_if.slave  bus
);
    // Half-period counter needs at least one bit even when CLK_DIV is 1.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(N_BITS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DIV_W-1:0]    r_div;
    logic [DIV_W-1:0]    w_div_nxt;
    logic [BIT_W-1:0]    r_bit;
    logic [BIT_W-1:0]    w_bit_nxt;
    logic [N_BITS-1:0]   r_shift;
    logic [N_BITS-1:0]   w_shift_nxt;
    logic [N_BITS-1:0]   w_shift_sl;
    logic                r_sck;
    logic                w_sck_nxt;
    logic                r_sdo;
    logic                w_sdo_nxt;
    logic                r_load;
    logic                w_load_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_div_end;

    assign w_div_end  = (r_div == DIV_LAST);
    assign w_shift_sl = r_shift << 1;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next value of every datapath register and registered output.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_sck_nxt   = r_sck;
        w_sdo_nxt   = r_sdo;
        w_load_nxt  = r_load;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_shift_nxt = bus.frame;
                    w_sdo_nxt   = bus.frame[N_BITS-1];
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_sck_nxt   = 1'b0;
                    w_load_nxt  = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_SETUP;
                end
            end

            S_SETUP: begin
                if (w_div_end) begin
                    w_div_nxt   = '0;
                    w_sck_nxt   = 1'b1;
                    w_state_nxt = S_HIGH;
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end

            S_HIGH: begin
                if (w_div_end) begin
                    w_div_nxt = '0;
                    w_sck_nxt = 1'b0;
                    if (r_bit == BIT_LAST) begin
                        // Last bit stays on sdo through HOLD and into IDLE.
                        w_state_nxt = S_HOLD;
                    end else begin
                        // sdo moves on the falling edge so it is stable around the next rise.
                        w_shift_nxt = w_shift_sl;
                        w_sdo_nxt   = w_shift_sl[N_BITS-1];
                        w_bit_nxt   = r_bit + 1'b1;
                        w_state_nxt = S_LOW;
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end

            S_LOW: begin
                if (w_div_end) begin
                    w_div_nxt   = '0;
                    w_sck_nxt   = 1'b1;
                    w_state_nxt = S_HIGH;
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end

            S_HOLD: begin
                if (w_div_end) begin
                    w_div_nxt   = '0;
                    w_load_nxt  = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and output registers; every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_sck   <= 1'b0;
            r_sdo   <= 1'b0;
            r_load  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_sck   <= w_sck_nxt;
            r_sdo   <= w_sdo_nxt;
            r_load  <= w_load_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.sck  = r_sck;
    assign bus.sdo  = r_sdo;
    assign bus.load = r_load;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule
